signed_divider_16by8_control: RTL and testbench
===============================================

Name: signed_divider_16by8_control

Overview:
- Iterative signed divider, the inverse-direction companion of the 8-bit signed multiplier in the matrix datapath.
- Takes a 16-bit signed dividend (e.g. a product from the multiplier) and an 8-bit signed divisor.
- Produces a 16-bit signed quotient and an 8-bit signed remainder, one quotient bit per clock, using restoring division on magnitudes.
- Control FSM is built in, with a start/flag handshake.

Parameters:
- DW, 16, dividend and quotient width (bits, two's complement).
- VW, 8, divisor and remainder width (bits, two's complement).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- A  in  DW  signed dividend.
- B  in  VW  signed divisor.
- Q  out  DW  signed quotient, registered.
- R  out  VW  signed remainder, registered.
- busy  out  1  high from LOAD through SIGN inclusive.
- flag  out  1  result valid; level signal.
- dz  out  1  divide-by-zero indicator, valid while flag=1.
- ovf  out  1  overflow indicator, valid while flag=1.

Behaviour:
- Reset (async, any state): state=IDLE; Q=0, R=0, busy=0, flag=0, dz=0, ovf=0; iteration counter=0.
- Division rules:
  - Truncation toward zero.
  - sign(Q) = sign(A) XOR sign(B).
  - sign(R) = sign(A); R=0 allowed.
  - Invariant: A = Q*B + R with |R| < |B|.
- Internal widths:
  - |A| held as DW-bit unsigned (covers 32768).
  - |B| held as VW-bit unsigned (covers 128).
  - Partial remainder is VW+1 bits.
- State IDLE:
  - busy=0; outputs hold last result.
  - On start=1: latch A and B into internal registers, clear flag/dz/ovf, go to LOAD.
  - start=0: stay in IDLE.
- State LOAD (1 cycle):
  - Compute magnitudes and result signs.
  - Clear partial remainder; counter=0.
  - Set dz if B==0.
  - Set ovf if A==-2^(DW-1) and B==-1.
  - Go to DIV.
- State DIV (exactly DW cycles):
  - Each cycle: shift {rem, dividend} left by 1; trial-subtract |B|.
  - If no borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments; after the DW-th cycle (counter==DW-1) go to SIGN.
  - dz/ovf cases still run all DW cycles, keeping latency uniform.
- State SIGN (1 cycle): negate magnitudes where required, then apply the cases below. Go to DONE.
  - dz: Q=0, R=0.
  - ovf: Q=-2^(DW-1) (16'h8000), R=0.
  - otherwise: Q, R as computed.
- State DONE (1 cycle): flag=1, busy=0; go to IDLE. flag stays 1 in IDLE until the next accepted start.
- Latency: if start is sampled at edge k, flag is high after edge k+DW+3 (k+19 by default). Q, R, dz, ovf are stable on that same edge.
- Boundary conditions:
  - A/B changes after the accepting edge are ignored.
  - start while busy is ignored, not queued.
  - start held high continuously gives back-to-back operations. flag is high for exactly one cycle (the IDLE cycle), then cleared by the next accept.
  - Reset mid-DIV aborts the operation with no partial result visible.
  - B==-128 is valid (|B|=128).
  - A==-32768 with B not equal to -1 is valid.

Test Plan:
- A=100, B=7, start pulse -> after 19 cycles flag=1, Q=14, R=2, dz=0, ovf=0.
- A=-100, B=7 -> Q=-14 (16'hFFF2), R=-2 (8'hFE). A=100, B=-7 -> Q=-14, R=2. A=-100, B=-7 -> Q=14, R=-2.
- A=-32768, B=-1 -> Q=16'h8000, R=0, ovf=1. A=-32768, B=-128 -> Q=256, R=0, ovf=0. A=32767, B=1 -> Q=32767, R=0.
- A=1234, B=0 -> flag after 19 cycles, Q=0, R=0, dz=1. Next op A=9, B=3 -> dz cleared on accept, Q=3, R=0.
- Start held high for three operations with A/B changed mid-operation -> each result matches the operands latched at its accept edge. flag is high for 1 cycle between ops; busy is never high together with flag.
- Assert rst at DIV cycle 8 of A=500, B=3 -> all outputs 0 immediately. A fresh start then yields Q=166, R=2.

Source files
------------

// File: rtl/signed_divider_16by8_control.sv
// Iterative signed divider: DW-bit dividend / VW-bit divisor, restoring
// division on magnitudes, one quotient bit per clock, start/flag handshake.
module signed_divider_16by8_control #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          flag,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] A_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_SIGN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q;        // operands latched at the accept edge
  logic [VW-1:0] b_q;
  logic [DW-1:0] dvd_q;      // |A| shifting out, quotient bits shifting in
  logic [VW-1:0] mag_b_q;    // |B|, 128 fits unsigned
  logic [VW:0]   rem_q;      // partial remainder
  logic [CW-1:0] cnt_q;
  logic          neg_q_q, neg_r_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] r_q;
  logic          flag_q, dz_q, ovf_q;

  // One restoring step: shift in the next dividend bit and trial-subtract |B|.
  // The shifted remainder never exceeds 2*|B|-1, so VW+1 bits hold it.
  logic [VW:0]   shl;
  logic [VW+1:0] trial;
  logic          borrow;

  always_comb begin
    shl    = {rem_q[VW-1:0], dvd_q[DW-1]};
    trial  = {1'b0, shl} - {2'b00, mag_b_q};
    borrow = trial[VW+1];
  end

  // Next-state logic; dz/ovf operations still walk all DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (cnt_q == CW'(DW-1)) state_d = S_SIGN;
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and result registers, sequenced by the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      mag_b_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      flag_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          a_q    <= A;
          b_q    <= B;
          flag_q <= 1'b0;
          dz_q   <= 1'b0;
          ovf_q  <= 1'b0;
        end
        S_LOAD: begin
          // -(-2^(DW-1)) wraps to 2^(DW-1), which is correct as unsigned.
          dvd_q   <= a_q[DW-1] ? (~a_q + DW'(1)) : a_q;
          mag_b_q <= b_q[VW-1] ? (~b_q + VW'(1)) : b_q;
          neg_q_q <= a_q[DW-1] ^ b_q[VW-1];
          neg_r_q <= a_q[DW-1];
          rem_q   <= '0;
          cnt_q   <= '0;
          dz_q    <= (b_q == '0);
          ovf_q   <= (a_q == A_MIN) && (b_q == '1);
        end
        S_DIV: begin
          rem_q <= borrow ? shl : trial[VW:0];
          dvd_q <= {dvd_q[DW-2:0], ~borrow};
          cnt_q <= cnt_q + CW'(1);
        end
        S_SIGN: begin
          if (dz_q) begin
            q_q <= '0;
            r_q <= '0;
          end else if (ovf_q) begin
            q_q <= A_MIN;
            r_q <= '0;
          end else begin
            q_q <= neg_q_q ? (~dvd_q + DW'(1)) : dvd_q;
            r_q <= neg_r_q ? (~rem_q[VW-1:0] + VW'(1)) : rem_q[VW-1:0];
          end
        end
        S_DONE: flag_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_SIGN);
  assign flag = flag_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_signed_divider_16by8_control.sv
// Self-checking bench: cycle-level behavioural reference built from the
// divide rules (plain integer / and %) plus the handshake latency, checked
// every cycle, with directed literal cases pinning the reference.
module tb_signed_divider_16by8_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy, flag, dz, ovf;

  int vecs = 0;
  int errs = 0;

  signed_divider_16by8_control #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .flag(flag), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
  } res_t;

  // Reference division: truncating integer divide, remainder takes the
  // dividend's sign; B==0 and -32768/-1 are special-cased.
  function automatic res_t ref_div(input logic [15:0] a, input logic [7:0] b);
    res_t res;
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    res = '0;
    if (bi == 0) begin
      res.dz = 1'b1;
    end else if (ai == -32768 && bi == -1) begin
      res.ovf = 1'b1;
      res.q   = 16'h8000;
    end else begin
      res.q = 16'(ai / bi);
      res.r = 8'(ai % bi);
    end
    return res;
  endfunction

  // Cycle-level reference: phase counts edges since the accept edge.
  // Busy during phases 1..18, Q/R land on the edge into phase 19, and flag
  // rises on the edge that returns to idle (accept + 19).
  int   m_phase = 0;
  logic m_flag = 1'b0;
  logic [15:0] m_q = '0;
  logic [7:0]  m_r = '0;
  res_t p_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_flag  <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      p_res   <= '0;
    end else if (m_phase == 0) begin
      if (start) begin
        p_res   <= ref_div(A, B);
        m_phase <= 1;
        m_flag  <= 1'b0;
      end
    end else if (m_phase == 19) begin
      m_phase <= 0;
      m_flag  <= 1'b1;
    end else begin
      if (m_phase == 18) begin
        m_q <= p_res.q;
        m_r <= p_res.r;
      end
      m_phase <= m_phase + 1;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic e_busy;
      e_busy = (m_phase >= 1) && (m_phase <= 18);
      vecs++;
      if (busy !== e_busy || flag !== m_flag || Q !== m_q || R !== m_r ||
          (m_flag && (dz !== p_res.dz || ovf !== p_res.ovf))) begin
        errs++;
        $display("FAIL cycle t=%0t: got busy=%b flag=%b Q=%h R=%h dz=%b ovf=%b, want busy=%b flag=%b Q=%h R=%h dz=%b ovf=%b",
                 $time, busy, flag, Q, R, dz, ovf, e_busy, m_flag, m_q, m_r, p_res.dz, p_res.ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Single-pulse operation with literal expectations and a latency check.
  task automatic op(input logic [15:0] a, input logic [7:0] b,
                    input logic [15:0] eq, input logic [7:0] er,
                    input logic edz, input logic eovf);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_state", {29'd0, busy, flag, dz}, 32'b100);
    A = 16'($urandom); B = 8'($urandom);   // must be ignored
    n = 1;
    while (!flag && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 20);
    chk("Q", Q, eq);
    chk("R", R, er);
    chk("dz_ovf", {dz, ovf}, {edz, eovf});
  endtask

  initial begin
    logic [7:0] bsel [8];
    bsel = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h7F, 8'h81, 8'h03, 8'hF9};

    repeat (3) @(negedge clk);
    chk("reset_outs", {Q, R, busy, flag, dz, ovf}, 32'd0);
    #2 rst = 1'b0;

    op(16'd100,    8'd7,           16'd14,   8'd2,    1'b0, 1'b0);
    op(-16'sd100,  8'd7,           16'hFFF2, 8'hFE,   1'b0, 1'b0);
    op(16'd100,    -8'sd7,         16'hFFF2, 8'd2,    1'b0, 1'b0);
    op(-16'sd100,  -8'sd7,         16'd14,   8'hFE,   1'b0, 1'b0);
    op(16'h8000,   8'hFF,          16'h8000, 8'd0,    1'b0, 1'b1);
    op(16'h8000,   8'h80,          16'd256,  8'd0,    1'b0, 1'b0);
    op(16'd32767,  8'd1,           16'd32767,8'd0,    1'b0, 1'b0);
    op(16'd1234,   8'd0,           16'd0,    8'd0,    1'b1, 1'b0);
    op(16'd9,      8'd3,           16'd3,    8'd0,    1'b0, 1'b0);
    op(16'h8000,   8'd7,           16'hEDB7, 8'hFF,   1'b0, 1'b0);

    // Start held high: back-to-back ops, operands churn every cycle.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 62; i++) begin
      A = 16'($urandom); B = 8'($urandom);
      @(negedge clk);
      if (busy && flag) chk("busy_and_flag", 32'd1, 32'd0);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    // Reset in the middle of DIV aborts cleanly.
    A = 16'd500; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_reset", {Q, R, busy, flag, dz, ovf}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    op(16'd500, 8'd3, 16'd166, 8'd2, 1'b0, 1'b0);

    // Random traffic with sparse starts and corner operands.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      A = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      B = ($urandom_range(0, 2) == 0) ? bsel[$urandom_range(0, 7)] : 8'($urandom);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
